// File: rtl/line_mem_arbiter_pkg.sv
// line_mem_arbiter_pkg: state encoding, requester ids and width defaults
// shared by the line memory arbiter, the caches and the backing memory.
package line_mem_arbiter_pkg;
  localparam int LINE_W_DEF  = 512;
  localparam int ADDR_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 8;
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN} state_t;
endpackage

// File: rtl/line_mem_arbiter_rr_arbiter2.sv
// line_mem_arbiter_rr_arbiter2: two-requester round-robin arbiter; bit 0 is the
// icache, bit 1 the dcache. On a tie the side that did not win last time wins.
module line_mem_arbiter_rr_arbiter2
  import line_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_q, last_d;
  assign grant[0] = req[0] & (~req[1] | (last_q == SRC_D));
  assign grant[1] = req[1] & (~req[0] | (last_q == SRC_I));
  assign last_d   = (advance && |grant) ? grant[1] : last_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= SRC_D;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: shares one line-wide memory port between icache refills and
// dcache refills/writebacks, with redirect-cancel and a sticky timeout flag.
module line_mem_arbiter
  import line_mem_arbiter_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d, err_q, err_d;
  logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic [1:0]        grant;
  logic              idle, to, done;
  assign idle = state_q == IDLE;
  assign to   = !idle && !mem_ready && cnt_q == CNT_W'(TIMEOUT - 1);
  assign done = !idle && (mem_ready || to);
  // A requester still showing req during its own ready pulse is the request just served.
  line_mem_arbiter_rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({d_req & ~d_ready_q, i_req & ~i_cancel & ~i_ready_q} & {2{idle}}),
    .advance(idle),
    .grant  (grant)
  );
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_d     = idle ? '0 : cnt_q + 1'b1;
    err_d     = err_q | to;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    if (idle && grant[0]) begin
      state_d = GRANT_I;
      addr_d  = i_addr & ~OFF_MASK;
      we_d    = 1'b0;
      wdata_d = '0;
    end else if (idle && grant[1]) begin
      state_d = GRANT_D;
      addr_d  = d_addr & ~OFF_MASK;
      we_d    = d_we;
      wdata_d = d_wdata;
    end else if (state_q == GRANT_I && done) begin
      state_d   = IDLE;
      i_ready_d = !i_cancel;
      i_rdata_d = i_cancel ? i_rdata_q : (to ? '0 : mem_rdata);
    end else if (state_q == GRANT_I && i_cancel) begin
      state_d = DRAIN;
    end else if (state_q == GRANT_D && done) begin
      state_d   = IDLE;
      d_ready_d = 1'b1;
      d_rdata_d = to ? '0 : (we_q ? d_rdata_q : mem_rdata);
    end else if (state_q == DRAIN && done) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
    end
  end
  assign mem_req   = !idle;
  assign busy      = !idle;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ready   = i_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb_line_mem_arbiter: directed stimulus with a ready-pulse scoreboard for the
// line memory arbiter.
module tb_line_mem_arbiter;
  typedef logic [511:0] line_t;
  typedef struct packed {logic is_d; line_t data;} exp_t;
  logic clk, reset;
  logic i_req, i_cancel, i_ready, d_req, d_we, d_ready;
  logic mem_req, mem_we, mem_ready, busy, err;
  logic [31:0] i_addr, d_addr, mem_addr;
  line_t i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  line_t la, lb, lc, le, lf, lj, l5a;
  exp_t expq[$];
  int errors = 0;
  int checks = 0;

  line_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkl(input string name, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_d, input line_t d);
    exp_t e;
    e.is_d = is_d;
    e.data = d;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset && (i_ready || d_ready)) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got i_ready=%b d_ready=%b expected no pulse", i_ready, d_ready);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk1("ready_both", i_ready & d_ready, 1'b0);
        chk1("ready_src", d_ready, e.is_d);
        chkl("rdata", d_ready ? d_rdata : i_rdata, e.data);
      end
    end
  end

  // Called one step after the edge that starts the first granted cycle.
  task automatic serve(input int lat, input line_t rd, input logic [31:0] ea,
                       input logic ewe, input line_t ewd, input int cancel_at);
    for (int k = 1; k <= lat; k++) begin
      i_cancel = (k == cancel_at);
      if (k == lat) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
      chk1("mem_req_hold", mem_req, 1'b1);
      chk32("mem_addr", mem_addr, ea);
      chk1("mem_we", mem_we, ewe);
      chkl("mem_wdata", mem_wdata, ewd);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    i_cancel  = 1'b0;
  endtask

  task automatic gap();
    @(negedge clk);
    chk1("idle_gap", mem_req, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    la = {64{8'hA1}}; lb = {64{8'hB2}}; lc = {64{8'hC3}}; le = {64{8'hE5}};
    lf = {64{8'hF6}}; lj = {64{8'h77}}; l5a = {64{8'h5A}};
    reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0; i_cancel = 1'b0;
    i_req = 1'b1; i_addr = 32'h2008; d_req = 1'b1; d_addr = 32'h3004; d_we = 1'b0; d_wdata = '0;
    repeat (3) begin
      @(negedge clk);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_i_ready", i_ready, 1'b0);
      chk1("rst_d_ready", d_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    push(1'b0, la);
    serve(4, la, 32'h2000, 1'b0, '0, 0);
    i_req = 1'b0;
    gap();
    push(1'b1, lb);
    serve(4, lb, 32'h3000, 1'b0, '0, 0);
    d_req = 1'b0;
    gap();
    i_req = 1'b1; i_addr = 32'h4010;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1044; d_wdata = l5a;
    @(posedge clk); #1;
    push(1'b0, lc);
    serve(2, lc, 32'h4000, 1'b0, '0, 0);
    i_req = 1'b0;
    gap();
    push(1'b1, lb);
    serve(3, lj, 32'h1040, 1'b1, l5a, 0);
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    gap();
    i_req = 1'b1; i_addr = 32'h6000;
    d_req = 1'b1; d_addr = 32'h7000;
    @(posedge clk); #1;
    serve(5, lj, 32'h6000, 1'b0, '0, 3);
    i_req = 1'b0;
    @(negedge clk);
    chk1("drain_gap", mem_req, 1'b0);
    chkl("i_rdata_kept", i_rdata, lc);
    @(posedge clk); #1;
    push(1'b1, le);
    serve(3, le, 32'h7000, 1'b0, '0, 0);
    d_req = 1'b0;
    gap();
    i_req = 1'b1; i_addr = 32'h8000; i_cancel = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk1("cancel_ignored", mem_req, 1'b0);
    end
    @(posedge clk); #1 i_cancel = 1'b0;
    @(posedge clk); #1;
    push(1'b0, '0);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
    end
    chk32("timeout_cycles", n, 255);
    chk1("timeout_err", err, 1'b1);
    chk1("timeout_busy", busy, 1'b0);
    i_req = 1'b0;
    @(posedge clk); #1 d_req = 1'b1; d_addr = 32'h9000;
    @(posedge clk); #1;
    push(1'b1, lf);
    serve(3, lf, 32'h9000, 1'b0, '0, 0);
    d_req = 1'b0;
    @(negedge clk);
    chk1("err_sticky", err, 1'b1);
    @(posedge clk); #1 d_req = 1'b1; d_addr = 32'hA000;
    @(posedge clk); #1;
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk1("async_mem_req", mem_req, 1'b0);
    chk1("async_busy", busy, 1'b0);
    chk1("async_d_ready", d_ready, 1'b0);
    chk1("async_err", err, 1'b0);
    d_req = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b1; mem_rdata = lj;
    @(posedge clk); #1 mem_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk1("no_stale_d_ready", d_ready, 1'b0);
      chk1("post_reset_idle", busy, 1'b0);
    end
    chk32("queue_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
